// File: rtl/console_uart_pkg.sv
// Shared constants for the console UART transmitter: bus map, STATUS bit
// layout and FSM state encoding. Macro: CONSOLE_TX_PARITY_EN adds the PARITY state.
package console_uart_pkg;

   localparam logic [31:0] STATUS_ADDR = 32'hE000_0000;
   localparam logic [31:0] DATA_ADDR   = 32'hE000_0004;
   localparam logic [31:0] WIN_BASE    = 32'hE000_0000;
   localparam logic [31:0] WIN_MASK    = 32'hFFFF_FF00;

   localparam int unsigned ST_BIT_FULL    = 0;
   localparam int unsigned ST_BIT_BUSY    = 1;
   localparam int unsigned ST_BIT_EMPTY   = 2;
   localparam int unsigned ST_BIT_OVERRUN = 3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef CONSOLE_TX_PARITY_EN
      ST_PARITY = 3'd4,
`endif
      ST_STOP   = 3'd3
   } state_t;

endpackage

// File: rtl/console_tx_fifo.sv
// Synchronous byte FIFO feeding the console transmitter.
// Push is dropped when full (pre-edge), pop ignored when empty.
// Macro: none used here (CONSOLE_TX_PARITY_EN affects only the top).
module console_tx_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push,
   input  logic [WIDTH-1:0]               wdata,
   input  logic                           pop,
   output logic [WIDTH-1:0]               rdata_c,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;
   logic [CNT_W-1:0] cnt_nxt;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign cnt_nxt = count + CNT_W'(do_push) - CNT_W'(do_pop);
   assign rdata_c = mem[rd_ptr];

   // Storage array; no reset needed, contents are qualified by count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Pointers, occupancy and registered full/empty flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= cnt_nxt;
         full  <= (cnt_nxt == CNT_W'(DEPTH));
         empty <= (cnt_nxt == '0);
      end
   end

endmodule

// File: rtl/console_uart.sv
// Console UART transmitter: bus-mapped DATA/STATUS registers, byte FIFO,
// and 8N1 serializer. Macro CONSOLE_TX_PARITY_EN adds an even-parity bit.
import console_uart_pkg::*;

module console_uart_tx #(
   parameter int unsigned CLK_DIV    = 434,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ram_cen,
   input  logic        ram_wen,
   input  logic [3:0]  ram_flag,
   input  logic [31:0] ram_addr,
   input  logic [31:0] ram_wdata,
   output logic [31:0] ram_rdata,
   output logic        tx,
   output logic        irq_tx_empty
);

   localparam int unsigned BAUD_W = $clog2(CLK_DIV);
   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

   state_t            state;
   state_t            state_nxt;
   logic [BAUD_W-1:0] baud_cnt;
   logic [BAUD_W-1:0] baud_nxt;
   logic [2:0]        bit_cnt;
   logic [2:0]        bit_cnt_nxt;
   logic [7:0]        shreg;
   logic [7:0]        shreg_nxt;
`ifdef CONSOLE_TX_PARITY_EN
   logic              par_bit;
   logic              par_nxt;
`endif
   logic              tx_nxt;
   logic              irq_nxt;
   logic              bit_done;
   logic              pop;
   logic              busy;
   logic              in_window;
   logic              push_req;
   logic              push_ok;
   logic              rd_req;
   logic              status_rd;
   logic              ovr_evt;
   logic              overrun;
   logic [31:0]       status_word;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic [CNT_W-1:0]  fifo_cnt_nxt;
   logic [7:0]        fifo_head;
   logic              unused_bits;

   assign unused_bits = ^{ram_wdata[31:8], ram_flag[3:1]};

   assign in_window = (ram_addr & WIN_MASK) == WIN_BASE;
   assign push_req  = ram_cen & ram_wen & (ram_addr == DATA_ADDR) & ram_flag[0];
   assign push_ok   = push_req & ~fifo_full;
   assign ovr_evt   = push_req & fifo_full;
   assign rd_req    = ram_cen & ~ram_wen & in_window;
   assign status_rd = rd_req & (ram_addr == STATUS_ADDR);
   assign bit_done  = (baud_cnt == BAUD_W'(CLK_DIV - 1));
   assign busy      = (state != ST_IDLE);
   assign fifo_cnt_nxt = fifo_count + CNT_W'(push_ok) - CNT_W'(pop);

   console_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push_req),
      .wdata   (ram_wdata[7:0]),
      .pop     (pop),
      .rdata_c (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic; a pop always coincides with entering START.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               state_nxt = ST_START;
               pop       = 1'b1;
            end
         end
         ST_START: begin
            if (bit_done) state_nxt = ST_DATA;
         end
         ST_DATA: begin
`ifdef CONSOLE_TX_PARITY_EN
            if (bit_done && bit_cnt == 3'd7) state_nxt = ST_PARITY;
`else
            if (bit_done && bit_cnt == 3'd7) state_nxt = ST_STOP;
`endif
         end
`ifdef CONSOLE_TX_PARITY_EN
         ST_PARITY: begin
            if (bit_done) state_nxt = ST_STOP;
         end
`endif
         ST_STOP: begin
            if (bit_done) begin
               if (!fifo_empty) begin
                  state_nxt = ST_START;
                  pop       = 1'b1;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Output/datapath next values; tx is computed for the upcoming state.
   always_comb begin
      baud_nxt    = (state == ST_IDLE || bit_done) ? '0 : baud_cnt + BAUD_W'(1);
      bit_cnt_nxt = bit_cnt;
      shreg_nxt   = shreg;
`ifdef CONSOLE_TX_PARITY_EN
      par_nxt     = par_bit;
`endif
      if (pop) begin
         shreg_nxt   = fifo_head;
         bit_cnt_nxt = 3'd0;
`ifdef CONSOLE_TX_PARITY_EN
         par_nxt     = ^fifo_head;
`endif
      end else if (state == ST_DATA && bit_done) begin
         shreg_nxt   = {1'b0, shreg[7:1]};
         bit_cnt_nxt = bit_cnt + 3'd1;
      end
      case (state_nxt)
         ST_START:  tx_nxt = 1'b0;
         ST_DATA:   tx_nxt = shreg_nxt[0];
`ifdef CONSOLE_TX_PARITY_EN
         ST_PARITY: tx_nxt = par_nxt;
`endif
         default:   tx_nxt = 1'b1;
      endcase
      irq_nxt = (fifo_cnt_nxt == '0) && (state_nxt == ST_IDLE);
   end

   // Serializer registers and registered line/interrupt outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         baud_cnt     <= '0;
         bit_cnt      <= '0;
         shreg        <= '0;
`ifdef CONSOLE_TX_PARITY_EN
         par_bit      <= 1'b0;
`endif
         tx           <= 1'b1;
         irq_tx_empty <= 1'b1;
      end else begin
         baud_cnt     <= baud_nxt;
         bit_cnt      <= bit_cnt_nxt;
         shreg        <= shreg_nxt;
`ifdef CONSOLE_TX_PARITY_EN
         par_bit      <= par_nxt;
`endif
         tx           <= tx_nxt;
         irq_tx_empty <= irq_nxt;
      end
   end

   // STATUS word assembled from pre-edge state.
   always_comb begin
      status_word                 = '0;
      status_word[ST_BIT_FULL]    = fifo_full;
      status_word[ST_BIT_BUSY]    = busy;
      status_word[ST_BIT_EMPTY]   = fifo_empty;
      status_word[ST_BIT_OVERRUN] = overrun;
   end

   // Bus read data and sticky overrun; a new overrun beats a clearing read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_rdata <= '0;
         overrun   <= 1'b0;
      end else begin
         if (rd_req) ram_rdata <= status_rd ? status_word : 32'd0;
         if (ovr_evt)        overrun <= 1'b1;
         else if (status_rd) overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_console_uart_tx.sv
// Self-checking bench for console_uart_tx with a queue-based line model.
// Honours CONSOLE_TX_PARITY_EN to expect 11-bit frames.
module tb_console_uart_tx;

   localparam int unsigned CLK_DIV = 4;
   localparam int unsigned DEPTH   = 4;
`ifdef CONSOLE_TX_PARITY_EN
   localparam int unsigned FRAME_BITS = 11;
   localparam logic [7:0]  CAP_BYTE   = 8'h07;
   localparam logic [43:0] CAP_EXP    = 44'hFF00000FFF0;
`else
   localparam int unsigned FRAME_BITS = 10;
   localparam logic [7:0]  CAP_BYTE   = 8'h41;
   localparam logic [39:0] CAP_EXP    = 40'hF0F00000F0;
`endif
   localparam int unsigned FRAME_CYC = FRAME_BITS * CLK_DIV;
   localparam logic [31:0] A_STATUS  = 32'hE000_0000;
   localparam logic [31:0] A_DATA    = 32'hE000_0004;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ram_cen, ram_wen;
   logic [3:0]  ram_flag;
   logic [31:0] ram_addr, ram_wdata, ram_rdata;
   logic        tx, irq_tx_empty;

   int n_checks = 0;
   int n_fail   = 0;

   console_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .ram_cen(ram_cen), .ram_wen(ram_wen),
      .ram_flag(ram_flag), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .tx(tx), .irq_tx_empty(irq_tx_empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0]  mq[$];      // bytes waiting in the FIFO
   bit          lineq[$];   // tx value for each remaining cycle of frames in flight
   bit          m_ovr;
   logic [31:0] m_rdata;
   int          pre_size;
   bit          pre_busy, push_req, st_rd;
   logic [7:0]  pb;
   bit          exp_tx, exp_irq;

   function automatic bit in_win(input logic [31:0] a);
      return a[31:8] == 24'hE00000;
   endfunction

   function automatic bit frame_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
`ifdef CONSOLE_TX_PARITY_EN
      if (k == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   // Model update on each rising edge, then compare the DUT against it.
   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         lineq.delete();
         m_ovr   = 1'b0;
         m_rdata = 32'd0;
      end else begin
         pre_size = mq.size();
         pre_busy = (lineq.size() != 0);
         st_rd    = 1'b0;
         if (ram_cen && !ram_wen && in_win(ram_addr)) begin
            if (ram_addr == A_STATUS) begin
               m_rdata = {28'd0, m_ovr, pre_size == 0, pre_busy, pre_size == int'(DEPTH)};
               st_rd   = 1'b1;
            end else begin
               m_rdata = 32'd0;
            end
         end
         push_req = ram_cen && ram_wen && ram_addr == A_DATA && ram_flag[0];
         if (push_req && pre_size == int'(DEPTH)) m_ovr = 1'b1;
         else if (st_rd)                          m_ovr = 1'b0;
         if (lineq.size() != 0) void'(lineq.pop_front());
         if (lineq.size() == 0 && pre_size > 0) begin
            pb = mq.pop_front();
            for (int k = 0; k < int'(FRAME_BITS); k++)
               for (int c = 0; c < int'(CLK_DIV); c++) lineq.push_back(frame_bit(pb, k));
         end
         if (push_req && pre_size < int'(DEPTH)) mq.push_back(ram_wdata[7:0]);
      end
      #1;
      exp_tx  = (lineq.size() != 0) ? lineq[0] : 1'b1;
      exp_irq = (mq.size() == 0) && (lineq.size() == 0);
      check("model_tx", 32'(tx), 32'(exp_tx));
      check("model_irq", 32'(irq_tx_empty), 32'(exp_irq));
      check("model_rdata", ram_rdata, m_rdata);
   end

   // ---------------- stimulus helpers ----------------
   task automatic bus_idle();
      ram_cen = 1'b0; ram_wen = 1'b0; ram_flag = 4'd0; ram_addr = 32'd0; ram_wdata = 32'd0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] f);
      @(negedge clk);
      ram_cen = 1'b1; ram_wen = 1'b1; ram_flag = f; ram_addr = a; ram_wdata = d;
   endtask

   task automatic rd(input logic [31:0] a);
      @(negedge clk);
      ram_cen = 1'b1; ram_wen = 1'b0; ram_flag = 4'd0; ram_addr = a; ram_wdata = 32'd0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus_idle();
      end
   endtask

   task automatic wait_idle();
      int k = 0;
      while (!(irq_tx_empty === 1'b1 && tx === 1'b1) && k < 3000) begin
         @(negedge clk);
         k++;
      end
      check("drain_timeout", 32'(k < 3000), 32'd1);
   endtask

   logic [FRAME_CYC-1:0] cap;
   int bad;
   logic [31:0] r;

   initial begin
      bus_idle();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_irq", 32'(irq_tx_empty), 32'd1);
      check("rst_rdata", ram_rdata, 32'd0);
      rst = 1'b0;
      idle(2);

      // Single frame, captured cycle by cycle from the edge after the push.
      wr(A_DATA, 32'(CAP_BYTE), 4'b0001);
      idle(1);
      for (int t = 0; t < int'(FRAME_CYC); t++) begin
         @(negedge clk);
         cap[t] = tx;
      end
      check("frame_shape", 32'(cap[31:0]), 32'(CAP_EXP[31:0]));
      check("frame_shape_hi", 32'(cap[FRAME_CYC-1:32]), 32'(CAP_EXP[FRAME_CYC-1:32]));
      @(negedge clk);
      check("frame_end_tx", 32'(tx), 32'd1);
      check("frame_end_irq", 32'(irq_tx_empty), 32'd1);

      // Overrun: six back-to-back writes into a 4-deep FIFO.
      for (int i = 0; i < 6; i++) wr(A_DATA, 32'h30 + 32'(i), 4'b0001);
      rd(A_STATUS);
      idle(1);
      check("ovr_full_bits", ram_rdata & 32'h9, 32'h9);
      check("ovr_not_empty", 32'(ram_rdata[2]), 32'd0);
      rd(A_STATUS);
      idle(1);
      check("ovr_cleared", 32'(ram_rdata[3]), 32'd0);
      wait_idle();

      // Byte lane 0 disabled: no push.
      wr(A_DATA, 32'h55, 4'b1110);
      idle(1);
      bad = 0;
      repeat (12) begin
         @(negedge clk);
         if (tx !== 1'b1 || irq_tx_empty !== 1'b1) bad++;
      end
      check("lane0_off_quiet", 32'(bad), 32'd0);

      // Read decode: other in-window reads zero, out-of-window holds.
      rd(A_STATUS);
      idle(1);
      check("status_idle", ram_rdata, 32'h4);
      rd(32'hE000_0008);
      idle(1);
      check("inwin_zero", ram_rdata, 32'd0);
      rd(A_STATUS);
      idle(1);
      rd(32'h4000_0000);
      idle(1);
      check("outwin_hold", ram_rdata, 32'h4);

      // Reset during data bit 3 of 0xA5 (bit3 = 0).
      wr(A_DATA, 32'hA5, 4'b0001);
      idle(1);
      repeat (18) @(negedge clk);
      check("pre_rst_tx", 32'(tx), 32'd0);
      rst = 1'b1;
      #1;
      check("async_rst_tx", 32'(tx), 32'd1);
      check("async_rst_irq", 32'(irq_tx_empty), 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("post_rst_rdata", ram_rdata, 32'd0);
      bad = 0;
      repeat (60) begin
         @(negedge clk);
         if (tx !== 1'b1) bad++;
      end
      check("no_resume", 32'(bad), 32'd0);
      rd(A_STATUS);
      idle(1);
      check("post_rst_status", ram_rdata, 32'h4);

      // Randomized bus traffic checked by the model every cycle.
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(99, 0);
         if (r < 45) begin
            wr(A_DATA, $urandom, ($urandom_range(3, 0) == 0) ? 4'b1110 : 4'($urandom) | 4'b0001);
         end else if (r < 60) begin
            rd(A_STATUS);
         end else if (r < 70) begin
            rd(32'hE000_0000 | 32'($urandom_range(255, 1)));
         end else if (r < 80) begin
            rd($urandom & 32'h7FFF_FFFF);
         end else begin
            idle(1);
         end
      end
      idle(1);
      wait_idle();

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
